// File: rtl/itch_pkg.sv
// Shared ITCH decoder definitions: packed decoded-record layout and message-type codes.
package itch_pkg;

   localparam int ITCH_DATA_W  = 160;

   // Decoded record, LSB first: shares | new_ref | orig_ref
   localparam int SHARES_LSB   = 0;
   localparam int SHARES_W     = 32;
   localparam int NEW_REF_LSB  = 32;
   localparam int REF_W        = 64;
   localparam int ORIG_REF_LSB = 96;

   // ASCII message-type codes
   localparam logic [7:0] MSG_ADD     = 8'h41;  // "A"
   localparam logic [7:0] MSG_CANCEL  = 8'h58;  // "X"
   localparam logic [7:0] MSG_DELETE  = 8'h44;  // "D"
   localparam logic [7:0] MSG_REPLACE = 8'h55;  // "U"
   localparam logic [7:0] MSG_EXEC    = 8'h45;  // "E"

endpackage

// File: rtl/decoder_output_arbiter_if.sv
// Bundle between the decoder bank, the arbiter and the order-book updater.
interface decoder_output_arbiter_if
   import itch_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int DATA_W  = ITCH_DATA_W,
   parameter int CNT_W   = 16
);
   localparam int SRC_W = $clog2(NUM_SRC);

   logic [NUM_SRC-1:0]        src_valid;
   logic [NUM_SRC*DATA_W-1:0] src_data;
   logic                      clear_stats;

   // Output stream: a message transfers on a rising edge where out_valid && out_ready.
   // Once out_valid is high, out_data/out_src hold until that transfer; out_valid never
   // depends combinationally on out_ready. src_valid is a one-cycle pulse with no ready.
   logic                      out_valid;
   logic                      out_ready;
   logic [DATA_W-1:0]         out_data;
   logic [SRC_W-1:0]          out_src;

   logic [NUM_SRC-1:0]        overflow;
   logic [CNT_W-1:0]          drop_count;

   modport master (
      output src_valid, src_data, clear_stats, out_ready,
      input  out_valid, out_data, out_src, overflow, drop_count
   );

   modport slave (
      input  src_valid, src_data, clear_stats, out_ready,
      output out_valid, out_data, out_src, overflow, drop_count
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping to 0.
module rr_arbiter #(
   parameter int NUM_SRC = 4,
   localparam int SRC_W  = $clog2(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [SRC_W-1:0]   ptr,
   output logic [NUM_SRC-1:0] gnt,
   output logic [SRC_W-1:0]   gnt_idx,
   output logic               gnt_any
);

   logic [SRC_W-1:0] cand;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      cand    = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         cand = SRC_W'((int'(ptr) + k) % NUM_SRC);
         if (!gnt_any && req[cand]) begin
            gnt_any   = 1'b1;
            gnt[cand] = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/decoder_output_arbiter.sv
// Merges one-cycle decoder pulses through per-source holding slots onto a registered
// valid/ready stream, round-robin between sources, with sticky drop flags and a drop counter.
module decoder_output_arbiter
   import itch_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int DATA_W  = ITCH_DATA_W,
   parameter int CNT_W   = 16
) (
   input logic                   clk,
   input logic                   rst_n,
   decoder_output_arbiter_if.slave bus
);

   localparam int SRC_W = $clog2(NUM_SRC);
   localparam int PC_W  = $clog2(NUM_SRC + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [NUM_SRC-1:0] slot_full;
   logic [DATA_W-1:0]  slot_data [NUM_SRC];

   logic               out_valid_q;
   logic [DATA_W-1:0]  out_data_q;
   logic [SRC_W-1:0]   out_src_q;
   logic [SRC_W-1:0]   rr_ptr;
   logic [NUM_SRC-1:0] overflow_q;
   logic [CNT_W-1:0]   drop_count_q;

   logic               load_en;
   logic [NUM_SRC-1:0] gnt;
   logic [NUM_SRC-1:0] granted;
   logic [SRC_W-1:0]   gnt_idx;
   logic               gnt_any;
   logic [SRC_W-1:0]   ptr_next;
   logic [NUM_SRC-1:0] load;
   logic [NUM_SRC-1:0] drop;
   logic [PC_W-1:0]    drop_n;
   logic [CNT_W-1:0]   cnt_base;
   logic [CNT_W:0]     cnt_sum;
   logic [CNT_W-1:0]   cnt_next;

   rr_arbiter #(.NUM_SRC(NUM_SRC)) u_rr (
      .req     (slot_full),
      .ptr     (rr_ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   // out_ready reaches only the grant and slot enables, never the output register's inputs directly.
   assign load_en  = !out_valid_q || bus.out_ready;
   assign granted  = (load_en && gnt_any) ? gnt : '0;
   assign ptr_next = (gnt_idx == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_idx + SRC_W'(1);

   // A slot being drained this cycle can accept a new pulse without loss.
   always_comb begin
      load   = '0;
      drop   = '0;
      drop_n = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         load[i] = bus.src_valid[i] && (!slot_full[i] || granted[i]);
         drop[i] = bus.src_valid[i] && slot_full[i] && !granted[i];
         drop_n  = drop_n + PC_W'(drop[i]);
      end
   end

   always_comb begin
      cnt_base = bus.clear_stats ? '0 : drop_count_q;
      cnt_sum  = {1'b0, cnt_base} + (CNT_W + 1)'(drop_n);
      cnt_next = cnt_sum[CNT_W] ? CNT_MAX : cnt_sum[CNT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         slot_full    <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_src_q    <= '0;
         rr_ptr       <= '0;
         overflow_q   <= '0;
         drop_count_q <= '0;
      end else begin
         slot_full <= (slot_full & ~granted) | load;
         if (load_en) begin
            out_valid_q <= gnt_any;
            if (gnt_any) begin
               out_data_q <= slot_data[gnt_idx];
               out_src_q  <= gnt_idx;
               rr_ptr     <= ptr_next;
            end
         end
         overflow_q   <= bus.clear_stats ? drop : (overflow_q | drop);
         drop_count_q <= cnt_next;
      end
   end

   // Payload needs no reset: slot_full alone qualifies it.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_SRC; i++) begin
         if (load[i]) slot_data[i] <= bus.src_data[i*DATA_W +: DATA_W];
      end
   end

   assign bus.out_valid  = out_valid_q;
   assign bus.out_data   = out_data_q;
   assign bus.out_src    = out_src_q;
   assign bus.overflow   = overflow_q;
   assign bus.drop_count = drop_count_q;

endmodule

// File: tb/tb_decoder_output_arbiter.sv
// Bench for decoder_output_arbiter: directed scenarios plus a randomized run against a reference model.
module tb_decoder_output_arbiter;

   localparam int NUM_SRC = 4;
   localparam int DATA_W  = 160;
   localparam int CNT_W   = 4;
   localparam int SRC_W   = 2;
   localparam int CNT_MAX = 15;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   decoder_output_arbiter_if #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

   decoder_output_arbiter #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [DATA_W-1:0] sd [NUM_SRC];

   always_comb begin
      bus.src_data = '0;
      for (int i = 0; i < NUM_SRC; i++) bus.src_data[i*DATA_W +: DATA_W] = sd[i];
   end

   int total = 0;
   int bad   = 0;

   // scoreboard: messages the model says will appear on the output, in order
   logic [SRC_W+DATA_W-1:0] exp_q [$];

   // reference model state
   bit                m_full [NUM_SRC];
   logic [DATA_W-1:0] m_data [NUM_SRC];
   bit                m_ov;
   logic [DATA_W-1:0] m_od;
   int                m_os, m_ptr, m_cnt;
   logic [NUM_SRC-1:0] m_ovf;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DATA_W-1:0] rand_data();
      logic [DATA_W-1:0] r;
      r = '0;
      for (int w = 0; w < DATA_W / 32; w++) r[w*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic do_reset();
      rst_n           = 1'b0;
      bus.src_valid   = '0;
      bus.clear_stats = 1'b0;
      bus.out_ready   = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < NUM_SRC; i++) begin
         m_full[i] = 1'b0;
         m_data[i] = '0;
      end
      m_ov = 1'b0; m_od = '0; m_os = 0; m_ptr = 0; m_cnt = 0; m_ovf = '0;
      exp_q.delete();
   endtask

   // One clock of the arbitration rules, applied to the inputs currently driven.
   task automatic model_step();
      int g, j, drops;
      bit load_en;
      logic [NUM_SRC-1:0] dmask;
      load_en = !m_ov || bus.out_ready;
      g = -1; drops = 0; dmask = '0;
      if (load_en) begin
         for (int k = 0; k < NUM_SRC; k++) begin
            j = (m_ptr + k) % NUM_SRC;
            if (g < 0 && m_full[j]) g = j;
         end
      end
      for (int i = 0; i < NUM_SRC; i++) begin
         if (bus.src_valid[i] && m_full[i] && g != i) begin
            drops++;
            dmask[i] = 1'b1;
         end
      end
      if (load_en) begin
         if (g >= 0) begin
            m_od = m_data[g]; m_os = g; m_ov = 1'b1;
            m_ptr = (g + 1) % NUM_SRC;
            m_full[g] = 1'b0;
            exp_q.push_back({SRC_W'(g), m_data[g]});
         end else begin
            m_ov = 1'b0;
         end
      end
      for (int i = 0; i < NUM_SRC; i++) begin
         if (bus.src_valid[i] && !dmask[i]) begin
            m_full[i] = 1'b1;
            m_data[i] = sd[i];
         end
      end
      if (bus.clear_stats) begin
         m_cnt = (drops > CNT_MAX) ? CNT_MAX : drops;
         m_ovf = dmask;
      end else begin
         m_cnt = (m_cnt + drops > CNT_MAX) ? CNT_MAX : m_cnt + drops;
         m_ovf = m_ovf | dmask;
      end
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", bus.out_valid); end
      total++; if (bus.out_data !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", bus.out_data); end
      total++; if (bus.out_src !== '0) begin bad++; $display("FAIL reset_src got=%0d exp=0", bus.out_src); end
      total++; if (bus.overflow !== '0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
      total++; if (bus.drop_count !== '0) begin bad++; $display("FAIL reset_drop_count got=%0d exp=0", bus.drop_count); end
   endtask

   task automatic test_single_pulse();
      logic [DATA_W-1:0] d_ab;
      d_ab = {20{8'hAB}};
      do_reset();
      sd[2] = d_ab;
      bus.src_valid = 4'b0100;
      tick();
      bus.src_valid = '0;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%0b exp=0", bus.out_valid); end
      tick();
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b exp=1", bus.out_valid); end
      total++; if (bus.out_src !== 2'd2) begin bad++; $display("FAIL single_src got=%0d exp=2", bus.out_src); end
      total++; if (bus.out_data !== d_ab) begin bad++; $display("FAIL single_data got=%h exp=%h", bus.out_data, d_ab); end
      tick();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_release got=%0b exp=0", bus.out_valid); end
   endtask

   task automatic test_simultaneous();
      logic [DATA_W-1:0] d [NUM_SRC];
      do_reset();
      for (int i = 0; i < NUM_SRC; i++) begin
         d[i]  = rand_data();
         sd[i] = d[i];
      end
      bus.src_valid = 4'b1111;
      tick();
      bus.src_valid = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         tick();
         total++;
         if (bus.out_valid !== 1'b1 || bus.out_src !== SRC_W'(i) || bus.out_data !== d[i]) begin
            bad++;
            $display("FAIL simul_order got v=%0b src=%0d exp v=1 src=%0d", bus.out_valid, bus.out_src, i);
         end
      end
      tick();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL simul_end got=%0b exp=0", bus.out_valid); end
      // pointer back at 0: of sources 1 and 3, source 1 wins first
      sd[1] = rand_data(); sd[3] = rand_data();
      bus.src_valid = 4'b1010;
      tick();
      bus.src_valid = '0;
      tick();
      total++; if (bus.out_src !== 2'd1) begin bad++; $display("FAIL simul_ptr_wrap got=%0d exp=1", bus.out_src); end
      tick();
      tick();
   endtask

   task automatic test_backpressure();
      logic [DATA_W-1:0] dx, da, db;
      dx = rand_data(); da = rand_data(); db = rand_data();
      do_reset();
      bus.out_ready = 1'b0;
      sd[0] = dx; bus.src_valid = 4'b0001;
      tick();
      bus.src_valid = '0;
      tick();
      sd[1] = da; bus.src_valid = 4'b0010;
      tick();
      total++; if (bus.out_data !== dx) begin bad++; $display("FAIL bp_hold1 got=%h exp=%h", bus.out_data, dx); end
      sd[1] = db; bus.src_valid = 4'b0010;
      tick();
      bus.src_valid = '0;
      tick();
      total++; if (bus.out_valid !== 1'b1 || bus.out_src !== 2'd0 || bus.out_data !== dx) begin
         bad++; $display("FAIL bp_hold2 got v=%0b src=%0d exp v=1 src=0", bus.out_valid, bus.out_src); end
      total++; if (bus.overflow !== 4'b0010) begin bad++; $display("FAIL bp_overflow got=%b exp=0010", bus.overflow); end
      total++; if (bus.drop_count !== 4'd1) begin bad++; $display("FAIL bp_drop_count got=%0d exp=1", bus.drop_count); end
      bus.out_ready = 1'b1;
      tick();
      total++; if (bus.out_valid !== 1'b1 || bus.out_src !== 2'd1 || bus.out_data !== da) begin
         bad++; $display("FAIL bp_first_kept got src=%0d data=%h exp src=1 data=%h", bus.out_src, bus.out_data, da); end
      tick();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_drained got=%0b exp=0", bus.out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [DATA_W-1:0] dp, dq;
      dp = rand_data(); dq = rand_data();
      do_reset();
      sd[0] = dp; bus.src_valid = 4'b0001;
      tick();
      sd[0] = dq; bus.src_valid = 4'b0001;
      tick();
      bus.src_valid = '0;
      total++; if (bus.out_valid !== 1'b1 || bus.out_data !== dp) begin bad++; $display("FAIL b2b_first got=%h exp=%h", bus.out_data, dp); end
      tick();
      total++; if (bus.out_valid !== 1'b1 || bus.out_data !== dq) begin bad++; $display("FAIL b2b_second got=%h exp=%h", bus.out_data, dq); end
      total++; if (bus.drop_count !== 4'd0 || bus.overflow !== 4'b0000) begin
         bad++; $display("FAIL b2b_no_drop got cnt=%0d ovf=%b exp 0", bus.drop_count, bus.overflow); end
      tick();
   endtask

   task automatic test_saturation_clear();
      do_reset();
      bus.out_ready = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) sd[i] = rand_data();
      bus.src_valid = 4'b0001;
      tick();
      bus.src_valid = '0;
      tick();
      bus.src_valid = 4'b1111;
      tick();
      tick();
      total++; if (bus.drop_count !== 4'd4) begin bad++; $display("FAIL sat_popcount got=%0d exp=4", bus.drop_count); end
      tick();
      tick();
      total++; if (bus.drop_count !== 4'd12) begin bad++; $display("FAIL sat_twelve got=%0d exp=12", bus.drop_count); end
      tick();
      tick();
      total++; if (bus.drop_count !== 4'd15) begin bad++; $display("FAIL sat_limit got=%0d exp=15", bus.drop_count); end
      total++; if (bus.overflow !== 4'b1111) begin bad++; $display("FAIL sat_overflow got=%b exp=1111", bus.overflow); end
      bus.src_valid = '0; bus.clear_stats = 1'b1;
      tick();
      total++; if (bus.drop_count !== 4'd0 || bus.overflow !== 4'b0000) begin
         bad++; $display("FAIL clear got cnt=%0d ovf=%b exp 0", bus.drop_count, bus.overflow); end
      bus.src_valid = 4'b0100;
      tick();
      bus.src_valid = '0; bus.clear_stats = 1'b0;
      total++; if (bus.drop_count !== 4'd1 || bus.overflow !== 4'b0100) begin
         bad++; $display("FAIL clear_with_drop got cnt=%0d ovf=%b exp cnt=1 ovf=0100", bus.drop_count, bus.overflow); end
   endtask

   task automatic test_reset_midstream();
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL mid_precond got=%0b exp=1", bus.out_valid); end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      total++; if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_src !== '0) begin
         bad++; $display("FAIL mid_reset_out got v=%0b src=%0d exp v=0 src=0", bus.out_valid, bus.out_src); end
      total++; if (bus.overflow !== '0 || bus.drop_count !== '0) begin
         bad++; $display("FAIL mid_reset_stats got ovf=%b cnt=%0d exp 0", bus.overflow, bus.drop_count); end
      bus.out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_stale cycle=%0d got=%0b exp=0", c, bus.out_valid); end
      end
   endtask

   task automatic rand_cycle(input logic [NUM_SRC-1:0] sv, input bit rdy, input bit clr);
      logic [SRC_W+DATA_W-1:0] got, exp;
      bus.src_valid = sv;
      for (int i = 0; i < NUM_SRC; i++) sd[i] = rand_data();
      bus.out_ready   = rdy;
      bus.clear_stats = clr;
      if (bus.out_valid && bus.out_ready) begin
         got = {bus.out_src, bus.out_data};
         total++;
         if (exp_q.size() == 0) begin
            bad++; $display("FAIL rand_sb_unexpected got src=%0d", bus.out_src);
         end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin bad++; $display("FAIL rand_sb_msg got=%h exp=%h", got, exp); end
         end
      end
      model_step();
      tick();
      total++; if (bus.out_valid !== m_ov) begin bad++; $display("FAIL rand_valid got=%0b exp=%0b", bus.out_valid, m_ov); end
      if (m_ov) begin
         total++; if (bus.out_src !== SRC_W'(m_os) || bus.out_data !== m_od) begin
            bad++; $display("FAIL rand_out got src=%0d exp src=%0d", bus.out_src, m_os); end
      end
      total++; if (bus.overflow !== m_ovf) begin bad++; $display("FAIL rand_overflow got=%b exp=%b", bus.overflow, m_ovf); end
      total++; if (bus.drop_count !== CNT_W'(m_cnt)) begin bad++; $display("FAIL rand_drop_count got=%0d exp=%0d", bus.drop_count, m_cnt); end
   endtask

   task automatic test_random();
      do_reset();
      model_reset();
      for (int c = 0; c < 500; c++) begin
         rand_cycle(NUM_SRC'($urandom_range(0, 15) & $urandom_range(0, 15)),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
      end
      for (int c = 0; c < 12; c++) rand_cycle('0, 1'b1, 1'b0);
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rand_leftover got=%0d exp=0", exp_q.size()); end
   endtask

   initial begin
      rst_n           = 1'b0;
      bus.src_valid   = '0;
      bus.clear_stats = 1'b0;
      bus.out_ready   = 1'b1;
      for (int i = 0; i < NUM_SRC; i++) sd[i] = '0;
      test_reset();
      test_single_pulse();
      test_simultaneous();
      test_backpressure();
      test_back_to_back();
      test_saturation_clear();
      test_reset_midstream();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
